// File: rtl/add_sub_pkg.sv
// Shared types and constants for the sequential add/sub unit.
//   state_e    : control states (IDLE, CALC, NEG, DONE)
//   OP_ADD/SUB : operation encodings on the op input
//   chunk_fit  : configuration check, WIDTH must be a whole number of CHUNKs
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  // True when width w splits into an integral number of c-bit slices.
  function automatic bit chunk_fit(input int unsigned w, input int unsigned c);
    return (c != 0) && ((w % c) == 0);
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit adder slice.
//   a, b : slice operands
//   cin  : carry in
//   s    : slice sum
//   cout : carry out
module add_sub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] sum_c;

  assign sum_c = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s     = sum_c[CHUNK-1:0];
  assign cout  = sum_c[CHUNK];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (ready only while idle)
//   x, y, op            : operands, op 0 = x+y, 1 = x-y
//   out_valid/out_ready : result handshake, outputs held until taken
//   result              : sum/difference (magnitude when sign = 1)
//   carry, overflow     : carry-out (sub: 1 = no borrow), signed overflow
//   zero, neg, sign     : final result == 0, raw MSB, magnitude sign
// Optional feature: define ADD_SUB_SEQ_MAG_EN to add the NEG pass that turns
// an underflowing subtract into |x - y| with sign = 1.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg,
  output logic             sign
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (!chunk_fit(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("add_sub_seq: WIDTH must be a multiple of CHUNK");
  end

  state_e            state, state_next;
  logic [WIDTH-1:0]  x_q, yb_q, r_q;
  logic              carry_q;
  logic [KW-1:0]     k_q;

  logic [CHUNK-1:0]  a_c, b_c, s_c;
  logic              cin_c, cout_c;
  logic              last_c, ovf_c;
  logic [WIDTH-1:0]  r_next_c;

`ifdef ADD_SUB_SEQ_MAG_EN
  logic              op_q;
  logic              ncarry_q;
  logic              neg_raw_q;
  logic              ovf_raw_q;
  logic              sign_q;
`endif

  assign last_c = (k_q == KW'(NCH - 1));
  // Overflow on the raw result; only meaningful on the last CALC slice.
  assign ovf_c  = (x_q[WIDTH-1] == yb_q[WIDTH-1]) && (s_c[CHUNK-1] != x_q[WIDTH-1]);

  // Slice adder shared between CALC (x + yb + c) and NEG (~r + 0 + c).
  always_comb begin
    a_c   = '0;
    b_c   = '0;
    cin_c = carry_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (k_q == KW'(i)) begin
        a_c = x_q[i*CHUNK +: CHUNK];
        b_c = yb_q[i*CHUNK +: CHUNK];
      end
    end
`ifdef ADD_SUB_SEQ_MAG_EN
    if (state == NEG) begin
      b_c   = '0;
      cin_c = (k_q == '0) ? 1'b1 : ncarry_q;
      for (int i = 0; i < int'(NCH); i++) begin
        if (k_q == KW'(i)) a_c = ~r_q[i*CHUNK +: CHUNK];
      end
    end
`endif
  end

  add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_c),
    .b    (b_c),
    .cin  (cin_c),
    .s    (s_c),
    .cout (cout_c)
  );

  // Working result with the current slice merged in.
  always_comb begin
    r_next_c = r_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (k_q == KW'(i)) r_next_c[i*CHUNK +: CHUNK] = s_c;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = CALC;
      CALC: begin
        if (last_c) begin
`ifdef ADD_SUB_SEQ_MAG_EN
          state_next = (op_q && !cout_c) ? NEG : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef ADD_SUB_SEQ_MAG_EN
      NEG:  if (last_c) state_next = DONE;
`endif
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and slice-serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      yb_q    <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
`ifdef ADD_SUB_SEQ_MAG_EN
      op_q      <= 1'b0;
      ncarry_q  <= 1'b0;
      neg_raw_q <= 1'b0;
      ovf_raw_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q     <= x;
            yb_q    <= (op == OP_SUB) ? ~y : y;
            carry_q <= op;
            k_q     <= '0;
`ifdef ADD_SUB_SEQ_MAG_EN
            op_q    <= op;
`endif
          end
        end
        CALC: begin
          r_q     <= r_next_c;
          carry_q <= cout_c;
          k_q     <= last_c ? '0 : k_q + KW'(1);
`ifdef ADD_SUB_SEQ_MAG_EN
          if (last_c) begin
            neg_raw_q <= s_c[CHUNK-1];
            ovf_raw_q <= ovf_c;
          end
`endif
        end
`ifdef ADD_SUB_SEQ_MAG_EN
        NEG: begin
          r_q      <= r_next_c;
          ncarry_q <= cout_c;
          k_q      <= last_c ? '0 : k_q + KW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  // Registered handshake and result/flag outputs, loaded on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
`ifdef ADD_SUB_SEQ_MAG_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (state == CALC && state_next == DONE) begin
        result   <= r_next_c;
        zero     <= (r_next_c == '0);
        carry    <= cout_c;
        neg      <= s_c[CHUNK-1];
        overflow <= ovf_c;
`ifdef ADD_SUB_SEQ_MAG_EN
        sign_q   <= 1'b0;
`endif
      end
`ifdef ADD_SUB_SEQ_MAG_EN
      if (state == NEG && state_next == DONE) begin
        result   <= r_next_c;
        zero     <= (r_next_c == '0);
        carry    <= carry_q;
        neg      <= neg_raw_q;
        overflow <= ovf_raw_q;
        sign_q   <= op_q & ~carry_q;
      end
`endif
    end
  end

`ifdef ADD_SUB_SEQ_MAG_EN
  assign sign = sign_q;
`else
  assign sign = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq (WIDTH=32, CHUNK=8): directed corner
// cases plus random operations against an arithmetic reference model.
module tb_add_sub_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned NCH   = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x, y;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry, overflow, zero, neg, sign;

  int n_tests = 0;
  int n_fail  = 0;

  add_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .neg       (neg),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model from the arithmetic definition of the operation.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic o,
                       output logic [31:0] res, output logic c, output logic v,
                       output logic z, output logic n, output logic s, output int lat);
    longint unsigned ua, ub, full;
    longint          sa, sb, sr;
    logic [31:0]     raw;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o) begin
      full = (ua - ub) & 64'h1_FFFF_FFFF;
      c    = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub;
      c    = (full > 64'hFFFF_FFFF);
      sr   = sa + sb;
    end
    raw = full[31:0];
    v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    n   = raw[31];
    s   = 1'b0;
    lat = NCH;
    res = raw;
`ifdef ADD_SUB_SEQ_MAG_EN
    if (o && (ua < ub)) begin
      res = 32'(ub - ua);
      s   = 1'b1;
      lat = 2 * NCH;
    end
`endif
    z = (res == 32'd0);
  endtask

  // One full transaction: accept, measure latency, hold, handshake.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input int hold);
    logic [31:0] e_res;
    logic        e_c, e_v, e_z, e_n, e_s;
    int          e_lat, cyc, w;
    model(a, b, o, e_res, e_c, e_v, e_z, e_n, e_s, e_lat);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({name, "/ready_before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; x = a; y = b; op = o; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Garbage on the inputs after acceptance must not matter.
    in_valid = 1'($urandom_range(0, 1));
    x = $urandom; y = $urandom; op = 1'($urandom_range(0, 1));
    check({name, "/busy_ready"}, 64'(in_ready), 64'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({name, "/out_valid"}, 64'(out_valid), 64'd1);
    check({name, "/latency"}, 64'(cyc), 64'(e_lat));
    for (int i = 0; i <= hold; i++) begin
      check({name, "/result"}, 64'(result), 64'(e_res));
      check({name, "/flags"}, {59'd0, carry, overflow, zero, neg, sign},
            {59'd0, e_c, e_v, e_z, e_n, e_s});
      check({name, "/hold_ready"}, {62'd0, out_valid, in_ready}, 64'b10);
      if (i < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "/after_hs"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  logic [31:0] corners [5];

  initial begin
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; op = 1'b0; out_ready = 1'b0;
    #12;
    check("reset/state", {61'd0, in_ready, out_valid, zero}, 64'b100);
    check("reset/result", 64'(result), 64'd0);
    check("reset/flags", {60'd0, carry, overflow, neg, sign}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("sub_5_3",  32'd5, 32'd3, 1'b1, 0);
    run_op("sub_3_5",  32'd3, 32'd5, 1'b1, 0);
    run_op("sub_hold", 32'h8000_0000, 32'd1, 1'b1, 5);

    // Reset during the second CALC cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; x = 32'd10; y = 32'd20; op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/handshake", {62'd0, in_ready, out_valid}, 64'b10);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 32'd1, 32'd1, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      run_op($sformatf("rnd%0d", t), a, b, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
